// File: rtl/flash_boot_loader_pkg.sv
// Shared types and constants for the SPI flash boot loader.
package flash_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    CMD,
    DATA,
    CS_HOLD,
    DONE
  } boot_state_t;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam int         CMD_BITS       = 32;
  localparam int         WORD_BITS      = 32;

  // Bytes arrive MSB first but are packed little-endian into the word.
  function automatic logic [4:0] byte_lane_bit(input logic [4:0] bit_idx);
    return {bit_idx[4:3], ~bit_idx[2:0]};
  endfunction

endpackage

// File: rtl/flash_boot_loader_sclk_gen.sv
// SPI mode 0 serial clock generator with one-cycle rise/fall strobes.
module flash_boot_sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic enable,
  output logic sclk_o,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int                CNT_W    = $clog2(SCLK_DIV + 1);
  localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(SCLK_DIV - 1);

  logic [CNT_W-1:0] half_cnt;
  logic             toggle;

  // Strobes mark the cycle whose closing edge flips sclk_o.
  always_comb begin
    toggle   = enable && (half_cnt == HALF_END);
    rise_stb = toggle && !sclk_o;
    fall_stb = toggle && sclk_o;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt <= '0;
      sclk_o   <= 1'b0;
    end else if (!enable) begin
      half_cnt <= '0;
      sclk_o   <= 1'b0;
    end else if (toggle) begin
      half_cnt <= '0;
      sclk_o   <= ~sclk_o;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/flash_boot_loader.sv
// Copies IMEM_DEPTH words from SPI flash into instruction memory, then
// releases the core from reset.
module flash_boot_loader
  import flash_boot_pkg::*;
#(
  parameter int          IMEM_DEPTH = 128,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          SCLK_DIV   = 2,
  parameter int          ADDR_W     = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              boot_en_i,
  output logic              sclk_o,
  output logic              cs_n_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_reset_n_o,
  output logic              boot_busy_o,
  output logic              boot_done_o
);

  localparam int                WAIT_W     = $clog2(2 * SCLK_DIV + 1);
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(SCLK_DIV - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(2 * SCLK_DIV - 1);
  localparam logic [4:0]        CMD_LAST   = 5'(CMD_BITS - 1);
  localparam logic [4:0]        WORD_LAST  = 5'(WORD_BITS - 1);
  localparam logic [ADDR_W:0]   LAST_WORD  = (ADDR_W + 1)'(IMEM_DEPTH - 1);
  localparam logic [31:0]       FRAME      = {FLASH_CMD_READ, FLASH_BASE};

  boot_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [4:0]        bit_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic [31:0]       word_q, word_next;
  logic              sclk_en, rise_stb, fall_stb;

  flash_boot_sclk_gen #(
    .SCLK_DIV(SCLK_DIV)
  ) u_sclk_gen (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .enable  (sclk_en),
    .sclk_o  (sclk_o),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb)
  );

  always_comb begin
    sclk_en   = (state_q == CMD) || (state_q == DATA);
    word_next = word_q;
    word_next[byte_lane_bit(bit_cnt)] = miso_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = boot_en_i ? CS_SETUP : DONE;
      CS_SETUP: if (wait_cnt == SETUP_LAST) state_d = CMD;
      CMD:      if (fall_stb && bit_cnt == CMD_LAST) state_d = DATA;
      DATA:     if (rise_stb && bit_cnt == WORD_LAST && word_cnt == LAST_WORD) state_d = CS_HOLD;
      CS_HOLD:  if (wait_cnt == HOLD_LAST) state_d = DONE;
      DONE:     state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // The bit counter wraps naturally from the command into each data word.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      word_q   <= '0;
    end else begin
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (state_q == CS_SETUP || state_q == CS_HOLD)
        wait_cnt <= wait_cnt + 1'b1;

      if (!sclk_en)
        bit_cnt <= '0;
      else if ((state_q == CMD && fall_stb) || (state_q == DATA && rise_stb))
        bit_cnt <= bit_cnt + 1'b1;

      if (state_q != DATA) begin
        word_cnt <= '0;
      end else if (rise_stb) begin
        word_q <= word_next;
        if (bit_cnt == WORD_LAST) word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cs_n_o         <= 1'b1;
      mosi_o         <= 1'b0;
      imem_we_o      <= 1'b0;
      imem_addr_o    <= '0;
      imem_wdata_o   <= '0;
      core_reset_n_o <= 1'b0;
      boot_busy_o    <= 1'b0;
      boot_done_o    <= 1'b0;
    end else begin
      imem_we_o      <= 1'b0;
      cs_n_o         <= !(state_q == CS_SETUP || state_q == CMD || state_q == DATA);
      boot_busy_o    <= (state_q == CS_SETUP || state_q == CMD ||
                         state_q == DATA || state_q == CS_HOLD);
      core_reset_n_o <= (state_q == DONE);
      boot_done_o    <= (state_q == DONE);
      case (state_q)
        CS_SETUP: mosi_o <= FRAME[31];
        CMD: begin
          if (fall_stb) mosi_o <= (bit_cnt == CMD_LAST) ? 1'b0 : FRAME[5'd30 - bit_cnt];
        end
        DATA: begin
          mosi_o <= 1'b0;
          if (rise_stb && bit_cnt == WORD_LAST) begin
            imem_we_o    <= 1'b1;
            imem_addr_o  <= word_cnt[ADDR_W-1:0];
            imem_wdata_o <= word_next;
          end
        end
        default:  mosi_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Self-checking bench: two loader instances (fast/base 0, slow/base 0x100000)
// against per-instance SPI flash models and a cycle-timing model.
module tb_flash_boot_loader;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic boot_en = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ a[23:16];
  endfunction

  // Hand-computed words: instance 0 at base 0, instance 1 at base 0x100000.
  function automatic logic [31:0] pin_word(input int g, input int w);
    case (g * 4 + w)
      0: return 32'h03020100;
      1: return 32'h07060504;
      2: return 32'h0B0A0908;
      3: return 32'h0F0E0D0C;
      4: return 32'h13121110;
      5: return 32'h17161514;
      6: return 32'h1B1A1918;
      7: return 32'h1F1E1D1C;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Expected outputs t clock edges after reset release, from the timing rules:
  // CS_SETUP d cycles, bit time 2d, 32 command bits then 32*n data bits,
  // CS_HOLD 2d cycles, every output one register stage behind the state.
  function automatic void predict(input int t, input bit en, input int d, input int n,
                                  input logic [31:0] frame,
                                  output logic sclk, output logic cs_n, output logic mosi,
                                  output logic we, output logic busy, output logic done,
                                  output int w);
    int u, ulast, tlast, k, idx;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; we = 1'b0; busy = 1'b0; done = 1'b0; w = 0;
    if (t < 2) return;
    if (!en) begin
      done = 1'b1;
      return;
    end
    ulast = d * (64 * n + 63);
    tlast = d + 1 + ulast;
    u     = t - (d + 1);
    cs_n  = (t > tlast);
    busy  = (t <= tlast + 2 * d);
    done  = (t > tlast + 2 * d);
    if (u >= 0 && u <= ulast) sclk = ((u / d) % 2) == 1;
    if (u < 64 * d) begin
      idx  = (u < 0) ? 0 : u / (2 * d);
      mosi = frame[31 - idx];
    end
    if (u >= d && (u % (2 * d)) == d) begin
      k = (u - d) / (2 * d);
      if (k >= 63 && ((k - 63) % 32) == 0 && ((k - 63) / 32) < n) begin
        we = 1'b1;
        w  = (k - 63) / 32;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic en, input int cycles);
    @(posedge clk);
    #2;
    reset_n = rn;
    boot_en = en;
    repeat (cycles - 1) @(posedge clk);
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int          D         = (g == 0) ? 1 : 3;
    localparam int          N         = 4;
    localparam logic [23:0] BASE      = (g == 0) ? 24'h000000 : 24'h100000;
    localparam logic [31:0] EXP_FRAME = (g == 0) ? 32'h03000000 : 32'h03100000;

    logic        sclk, cs_n, mosi, we, core_rn, busy, done;
    logic        miso = 1'b0;
    logic [1:0]  addr;
    logic [31:0] wdata;
    int          rise_cnt = 0;
    logic [31:0] cmd_sr = '0;
    int          t = 0;
    bit          en_q = 1'b0;

    flash_boot_loader #(
      .IMEM_DEPTH(N),
      .FLASH_BASE(BASE),
      .SCLK_DIV  (D)
    ) dut (
      .clk_i         (clk),
      .reset_n       (reset_n),
      .boot_en_i     (boot_en),
      .sclk_o        (sclk),
      .cs_n_o        (cs_n),
      .mosi_o        (mosi),
      .miso_i        (miso),
      .imem_we_o     (we),
      .imem_addr_o   (addr),
      .imem_wdata_o  (wdata),
      .core_reset_n_o(core_rn),
      .boot_busy_o   (busy),
      .boot_done_o   (done)
    );

    // Flash: latch the command on rising SCLK, then stream bytes on falling SCLK.
    initial forever begin
      @(posedge sclk or posedge cs_n);
      if (cs_n) begin
        rise_cnt = 0;
        cmd_sr   = '0;
      end else begin
        if (rise_cnt < 32) cmd_sr = {cmd_sr[30:0], mosi};
        rise_cnt = rise_cnt + 1;
        if (rise_cnt == 32) checkOutput($sformatf("i%0d mosi frame", g), cmd_sr, EXP_FRAME);
      end
    end

    initial forever begin
      int          idx;
      logic [7:0]  b;
      @(negedge sclk or posedge cs_n);
      if (cs_n) begin
        miso = 1'b0;
      end else if (rise_cnt >= 32) begin
        idx  = rise_cnt - 32;
        b    = flash_byte(cmd_sr[23:0] + 24'(idx / 8));
        miso = b[7 - (idx % 8)];
      end
    end

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        t <= 0;
      end else begin
        if (t == 0) en_q <= boot_en;
        t <= t + 1;
      end
    end

    initial forever begin
      logic        e_sclk, e_cs_n, e_mosi, e_we, e_busy, e_done;
      int          w;
      logic [31:0] e_word;
      @(negedge clk);
      predict(t, en_q, D, N, {8'h03, BASE}, e_sclk, e_cs_n, e_mosi, e_we, e_busy, e_done, w);
      checkOutput($sformatf("i%0d sclk t=%0d", g, t),    32'(sclk),    32'(e_sclk));
      checkOutput($sformatf("i%0d cs_n t=%0d", g, t),    32'(cs_n),    32'(e_cs_n));
      checkOutput($sformatf("i%0d mosi t=%0d", g, t),    32'(mosi),    32'(e_mosi));
      checkOutput($sformatf("i%0d we t=%0d", g, t),      32'(we),      32'(e_we));
      checkOutput($sformatf("i%0d busy t=%0d", g, t),    32'(busy),    32'(e_busy));
      checkOutput($sformatf("i%0d done t=%0d", g, t),    32'(done),    32'(e_done));
      checkOutput($sformatf("i%0d core_rn t=%0d", g, t), 32'(core_rn), 32'(e_done));
      if (e_we) begin
        e_word = {flash_byte(BASE + 24'(4 * w + 3)), flash_byte(BASE + 24'(4 * w + 2)),
                  flash_byte(BASE + 24'(4 * w + 1)), flash_byte(BASE + 24'(4 * w))};
        checkOutput($sformatf("i%0d addr w=%0d", g, w),      32'(addr), 32'(w));
        checkOutput($sformatf("i%0d wdata w=%0d", g, w),     wdata,     e_word);
        checkOutput($sformatf("i%0d wdata pin w=%0d", g, w), wdata,     pin_word(g, w));
      end
    end
  end

  initial begin
    $display("[TB] normal copy, then boot_en toggled while done");
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 1000);
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 5);
    applyStimulus(1'b1, 1'b0, 5);

    $display("[TB] skip path with boot_en low");
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 20);

    $display("[TB] reset in the middle of a copy");
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 200);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset cs_n",    32'(inst[0].cs_n),    32'd1);
    checkOutput("async reset sclk",    32'(inst[0].sclk),    32'd0);
    checkOutput("async reset core_rn", 32'(inst[0].core_rn), 32'd0);
    checkOutput("async reset busy",    32'(inst[0].busy),    32'd0);
    checkOutput("async reset wdata",   inst[0].wdata,        32'd0);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
